// File: rtl/router_pkg.sv
// Shared definitions for the router ingress path: header field layout,
// the reserved drop address and the ingress arbiter state encoding.
package router_pkg;

    // Header byte layout: {len[7:2], addr[1:0]}
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    // Packets addressed here are consumed from the source but never forwarded
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Arbiter FSM encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STATUS  = 3'd4;
    localparam logic [2:0] ST_DROP    = 3'd5;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester strictly
// after ptr, wrapping around, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld
);

    // Scan offsets from farthest to nearest so the nearest hit is the last write and wins
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the scan, so no path can infer a latch.
        idx       = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[W'(idx)]) begin
                grant_idx = W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Ingress arbiter for router_top: grants one of NUM_SRC sources round-robin,
// forwards its header and payload while honouring busy, appends the XOR
// parity byte, drops packets to ADDR_INVALID and reports per-packet status.
module router_ingress_arbiter
    import router_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ERR_LAT = 2,
    localparam int GW = $clog2(NUM_SRC)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           data_in,
    output logic                 pkt_valid,
    input  logic                 busy,
    input  logic                 error,
    output logic [GW-1:0]        grant_id,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output logic [7:0]           drop_cnt
);

    localparam int              SW        = (ERR_LAT > 1) ? $clog2(ERR_LAT) : 1;
    localparam logic [SW-1:0]   STAT_LAST = SW'(ERR_LAT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [2:0]       state;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    rr_ptr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       parity;
    logic [SW-1:0]    stat_cnt;

    logic [GW-1:0]    arb_idx;
    logic             arb_vld;
    logic [7:0]       src_bytes [NUM_SRC];
    logic [7:0]       cur_byte;
    logic             hdr_drop;

    rr_arbiter #(.N(NUM_SRC), .W(GW)) u_rr_arbiter (
        .req       (src_req),
        .ptr       (rr_ptr),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Split the flat source bus into per-source bytes for the granted-source mux
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) src_bytes[i] = src_data[8*i +: 8];
    end

    assign cur_byte = src_bytes[grant];
    assign hdr_drop = (hdr_addr(cur_byte) == ADDR_INVALID);
    assign grant_id = grant;

    // Router-side byte, valid flag and source handshake, decoded from state and busy
    always_comb begin
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        src_ready = '0;
        case (state)
            ST_HDR: begin
                if (hdr_drop) begin
                    // Dropped header is swallowed regardless of router busy
                    src_ready[grant] = 1'b1;
                end else begin
                    data_in          = cur_byte;
                    pkt_valid        = 1'b1;
                    src_ready[grant] = ~busy;
                end
            end
            ST_PAYLOAD: begin
                data_in          = cur_byte;
                pkt_valid        = 1'b1;
                src_ready[grant] = ~busy;
            end
            ST_PARITY: data_in = parity;
            // A zero-length drop has nothing left to consume
            ST_DROP:   src_ready[grant] = (len != '0);
            default: ;
        endcase
    end

    // Packet sequencing: grant, length/parity tracking, status sampling and drop counting
    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
        if (!resetn) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= GW'(NUM_SRC - 1);
            len      <= '0;
            cnt      <= '0;
            parity   <= 8'h00;
            stat_cnt <= '0;
            drop_cnt <= 8'h00;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant  <= arb_idx;
                        rr_ptr <= arb_idx;
                        state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hdr_drop || !busy) begin
                        len    <= hdr_len(cur_byte);
                        parity <= cur_byte;
                        cnt    <= '0;
                        if (hdr_drop)                   state <= ST_DROP;
                        else if (hdr_len(cur_byte) == '0) state <= ST_PARITY;
                        else                            state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        parity <= parity ^ cur_byte;
                        cnt    <= cnt + LEN_ONE;
                        if (cnt == len - LEN_ONE) state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        stat_cnt <= '0;
                        state    <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (stat_cnt == STAT_LAST) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= error;
                        state    <= ST_IDLE;
                    end else begin
                        stat_cnt <= stat_cnt + SW'(1);
                    end
                end
                ST_DROP: begin
                    if (len == '0 || cnt == len - LEN_ONE) begin
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + LEN_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Self-checking bench for router_ingress_arbiter. Source models feed bytes on
// src_ready; a negedge monitor pops expected bytes, parity and completion
// records from scoreboards filled when packets are queued.
module tb_router_ingress_arbiter;
    import router_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int ERR_LAT = 2;
    localparam int GW      = $clog2(NUM_SRC);
    localparam int BOUND   = 2000;

    typedef struct packed { logic valid; logic [7:0] data; } exp_byte_t;
    typedef struct packed { logic err; logic [GW-1:0] src; } exp_done_t;

    logic                 clock  = 1'b0;
    logic                 resetn = 1'b0;
    logic [NUM_SRC-1:0]   src_req  = '0;
    logic [8*NUM_SRC-1:0] src_data = '0;
    logic [NUM_SRC-1:0]   src_ready;
    logic [7:0]           data_in;
    logic                 pkt_valid;
    logic                 busy  = 1'b0;
    logic                 error = 1'b0;
    logic [GW-1:0]        grant_id;
    logic                 pkt_done;
    logic                 pkt_err;
    logic [7:0]           drop_cnt;

    router_ingress_arbiter #(.NUM_SRC(NUM_SRC), .ERR_LAT(ERR_LAT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .src_req   (src_req),
        .src_data  (src_data),
        .src_ready (src_ready),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .error     (error),
        .grant_id  (grant_id),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    exp_byte_t          exp_q [$];
    exp_done_t          done_q [$];
    logic [7:0]         src_q [NUM_SRC][$];
    logic [NUM_SRC-1:0] ready_n = '0;
    int                 compared   = 0;
    int                 mismatched = 0;
    int                 cyc        = 0;
    logic               in_pkt     = 1'b0;
    logic               err_valid  = 1'b0;
    logic               cur_err    = 1'b0;
    int                 err_edge   = -100;
    int                 rdy_cnt [NUM_SRC] = '{default: 0};
    int                 valid_cnt  = 0;
    int                 err_pulses = 0;
    logic [7:0]         last_parity = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_req[i] = (src_q[i].size() != 0);
            if (src_q[i].size() != 0) src_data[8*i +: 8] = src_q[i][0];
            else                      src_data[8*i +: 8] = 8'h00;
        end
    endtask

    function automatic logic srcs_pending();
        for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Queue a packet on a source and record what the router side must see
    task automatic send_pkt(input int src, input logic [7:0] hdr, input logic [7:0] seed, input logic err);
        logic [7:0] par;
        logic [7:0] b;
        int         len;
        logic       fwd;
        len = int'(hdr[7:2]);
        fwd = (hdr[1:0] != ADDR_INVALID);
        par = hdr;
        src_q[src].push_back(hdr);
        if (fwd) exp_q.push_back('{valid: 1'b1, data: hdr});
        for (int k = 0; k < len; k++) begin
            b = seed + 8'(17 * (k + 1));
            src_q[src].push_back(b);
            if (fwd) exp_q.push_back('{valid: 1'b1, data: b});
            par = par ^ b;
        end
        if (fwd) begin
            exp_q.push_back('{valid: 1'b0, data: par});
            done_q.push_back('{err: err, src: GW'(src)});
        end
        drive_srcs();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || srcs_pending()) && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (n >= BOUND) begin
            compared++; mismatched++;
            $display("FAIL %s_timeout: %0d bytes and %0d completions still expected after %0d cycles",
                     name, exp_q.size(), done_q.size(), n);
        end
        repeat (3) @(negedge clock);
    endtask

    // Source models: pop the byte the arbiter accepted at the previous edge
    initial forever begin
        @(posedge clock); #1;
        for (int i = 0; i < NUM_SRC; i++)
            if (ready_n[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        drive_srcs();
    end

    // Error stimulus: the planned value lands only on the sample edge; packets
    // expecting no error see a decoy pulse one edge earlier
    initial forever begin
        @(posedge clock); #1;
        error = err_valid && (((cyc == err_edge - 1) && cur_err) || ((cyc == err_edge - 2) && !cur_err));
    end

    // Router-side monitor and scoreboard
    initial begin : monitor
        exp_byte_t e;
        exp_done_t d;
        forever begin
            @(negedge clock);
            ready_n = resetn ? src_ready : '0;
            if (resetn) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (src_ready[i]) rdy_cnt[i]++;
                    if (src_ready[i] && !src_req[i]) begin
                        compared++; mismatched++;
                        $display("FAIL protocol: src_ready[%0d]=1 while src_req[%0d]=0", i, i);
                    end
                end
                if (pkt_valid) valid_cnt++;
                if (!busy && pkt_valid) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_byte: got data_in=%h pkt_valid=1, expected no transfer", data_in);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.valid !== 1'b1 || e.data !== data_in) begin
                            mismatched++;
                            $display("FAIL byte: got data_in=%h pkt_valid=1, expected data_in=%h pkt_valid=%b",
                                     data_in, e.data, e.valid);
                        end
                    end
                    in_pkt = 1'b1;
                end else if (!busy && in_pkt) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_parity: got data_in=%h pkt_valid=0, expected no transfer", data_in);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.valid !== 1'b0 || e.data !== data_in) begin
                            mismatched++;
                            $display("FAIL parity: got data_in=%h pkt_valid=0, expected data_in=%h pkt_valid=%b",
                                     data_in, e.data, e.valid);
                        end
                    end
                    in_pkt      = 1'b0;
                    last_parity = data_in;
                    if (done_q.size() != 0) begin
                        err_edge  = cyc + 1 + ERR_LAT;
                        cur_err   = done_q[0].err;
                        err_valid = 1'b1;
                    end
                end
                if (pkt_err && !pkt_done) begin
                    compared++; mismatched++;
                    $display("FAIL pkt_err_alone: got pkt_err=1 pkt_done=0, expected pkt_err only with pkt_done");
                end
                if (pkt_done) begin
                    compared++;
                    if (pkt_err) err_pulses++;
                    if (done_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_done: got pkt_done=1 grant_id=%0d, expected no completion", grant_id);
                    end else begin
                        d = done_q.pop_front();
                        if (pkt_err !== d.err || grant_id !== d.src || cyc != err_edge) begin
                            mismatched++;
                            $display("FAIL done: got pkt_err=%b grant_id=%0d cycle=%0d, expected pkt_err=%b grant_id=%0d cycle=%0d",
                                     pkt_err, grant_id, cyc, d.err, d.src, err_edge);
                        end
                    end
                    err_valid = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if (pkt_valid !== 1'b0 || data_in !== 8'h00 || src_ready !== '0) begin
            mismatched++;
            $display("FAIL reset_port: got pkt_valid=%b data_in=%h src_ready=%b, expected 0/00/0", pkt_valid, data_in, src_ready);
        end
        compared++;
        if (grant_id !== '0 || pkt_done !== 1'b0 || pkt_err !== 1'b0 || drop_cnt !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_status: got grant_id=%0d pkt_done=%b pkt_err=%b drop_cnt=%h, expected all 0",
                     grant_id, pkt_done, pkt_err, drop_cnt);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        @(posedge clock); #1;
        send_pkt(0, 8'h0C, 8'h00, 1'b0);
        @(negedge clock);
        compared++;
        if (pkt_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_early: got pkt_valid=%b in request cycle, expected 0", pkt_valid);
        end
        @(negedge clock);
        compared++;
        if (pkt_valid !== 1'b1 || data_in !== 8'h0C || grant_id !== 0) begin
            mismatched++;
            $display("FAIL latency: got pkt_valid=%b data_in=%h grant_id=%0d, expected 1/0C/0", pkt_valid, data_in, grant_id);
        end
        wait_drain("basic");
        compared++;
        if (last_parity !== 8'h0C) begin
            mismatched++;
            $display("FAIL basic_parity: got %h, expected 0C", last_parity);
        end
    endtask

    task automatic test_round_robin();
        @(posedge clock); #1;
        send_pkt(1, 8'h08, 8'h40, 1'b0);
        send_pkt(2, 8'h09, 8'h50, 1'b0);
        send_pkt(1, 8'h0E, 8'h60, 1'b0);
        send_pkt(2, 8'h05, 8'h70, 1'b0);
        wait_drain("round_robin");
        compared++;
        if (grant_id !== 2) begin
            mismatched++;
            $display("FAIL rr_last_grant: got grant_id=%0d, expected 2", grant_id);
        end
    endtask

    task automatic test_busy();
        @(posedge clock); #1;
        send_pkt(0, 8'h14, 8'hA0, 1'b0);
        repeat (3) @(posedge clock);
        #1 busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            compared++;
            if (pkt_valid !== 1'b1 || data_in !== 8'hC2 || src_ready !== '0) begin
                mismatched++;
                $display("FAIL busy_hold[%0d]: got pkt_valid=%b data_in=%h src_ready=%b, expected 1/C2/0",
                         i, pkt_valid, data_in, src_ready);
            end
        end
        @(posedge clock); #1;
        busy = 1'b0;
        wait_drain("busy");
    endtask

    task automatic test_drop();
        compared++;
        if (drop_cnt !== 8'h00) begin
            mismatched++;
            $display("FAIL drop_before: got drop_cnt=%h, expected 00", drop_cnt);
        end
        @(posedge clock); #1;
        rdy_cnt[3] = 0;
        valid_cnt  = 0;
        send_pkt(3, 8'h13, 8'h80, 1'b0);
        wait_drain("drop");
        compared++;
        if (rdy_cnt[3] != 5 || valid_cnt != 0 || drop_cnt !== 8'h01) begin
            mismatched++;
            $display("FAIL drop: got ready_cycles=%0d valid_cycles=%0d drop_cnt=%h, expected 5/0/01",
                     rdy_cnt[3], valid_cnt, drop_cnt);
        end
        // Zero-length drop: only the header is consumed
        @(posedge clock); #1;
        rdy_cnt[3] = 0;
        send_pkt(3, 8'h03, 8'h00, 1'b0);
        wait_drain("drop_len0");
        compared++;
        if (rdy_cnt[3] != 1 || drop_cnt !== 8'h02) begin
            mismatched++;
            $display("FAIL drop_len0: got ready_cycles=%0d drop_cnt=%h, expected 1/02", rdy_cnt[3], drop_cnt);
        end
    endtask

    task automatic test_len0();
        @(posedge clock); #1;
        send_pkt(1, 8'h02, 8'h00, 1'b0);
        wait_drain("len0");
        compared++;
        if (last_parity !== 8'h02) begin
            mismatched++;
            $display("FAIL len0_parity: got %h, expected 02", last_parity);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(posedge clock); #1;
        send_pkt(2, 8'h0C, 8'h30, 1'b0);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock); #1;
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        in_pkt    = 1'b0;
        err_valid = 1'b0;
        drive_srcs();
        @(negedge clock);
        compared++;
        if (pkt_valid !== 1'b0 || src_ready !== '0 || data_in !== 8'h00 || grant_id !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got pkt_valid=%b src_ready=%b data_in=%h grant_id=%0d, expected all 0",
                     pkt_valid, src_ready, data_in, grant_id);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        pulses = err_pulses;
        send_pkt(0, 8'h08, 8'h10, 1'b1);
        send_pkt(1, 8'h05, 8'h20, 1'b0);
        send_pkt(2, 8'h0A, 8'h30, 1'b0);
        send_pkt(3, 8'h04, 8'h40, 1'b0);
        @(negedge clock);
        @(negedge clock);
        compared++;
        if (grant_id !== 0 || pkt_valid !== 1'b1 || data_in !== 8'h08) begin
            mismatched++;
            $display("FAIL four_way_first: got grant_id=%0d pkt_valid=%b data_in=%h, expected 0/1/08",
                     grant_id, pkt_valid, data_in);
        end
        wait_drain("four_way");
        compared++;
        if (err_pulses - pulses != 1) begin
            mismatched++;
            $display("FAIL err_pulse: got %0d pkt_err pulses, expected 1", err_pulses - pulses);
        end
    endtask

    task automatic test_drop_saturate();
        @(posedge clock); #1;
        for (int i = 0; i < 260; i++) send_pkt(3, 8'h03, 8'h00, 1'b0);
        wait_drain("drop_saturate");
        compared++;
        if (drop_cnt !== 8'hFF) begin
            mismatched++;
            $display("FAIL drop_saturate: got drop_cnt=%h, expected FF", drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_busy();
        test_drop();
        test_len0();
        test_reset_mid();
        test_drop_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
